// File: rtl/fence_unit_if.sv
// Shared fence kind encoding and the request/memory/i-cache signal bundle of the fence unit.
// master = pipeline side driving requests and status, slave = fence_unit.
package fence_pkg;
  typedef enum logic [1:0] {
    fk_fence   = 2'd0,
    fk_fence_i = 2'd1,
    fk_invalid = 2'd2
  } fence_kind_t;
endpackage

interface fence_if;
  import fence_pkg::*;

  logic        req_valid;
  fence_kind_t req_kind;
  logic        req_ready;
  logic        sb_empty;
  logic        mem_busy;
  logic        ic_inv_req;
  logic        ic_inv_ack;
  logic        stall;
  logic        done;
  logic        redirect;
  logic        illegal;
  logic        timeout;

  modport master (
    output req_valid, req_kind, sb_empty, mem_busy, ic_inv_ack,
    input  req_ready, ic_inv_req, stall, done, redirect, illegal, timeout
  );

  modport slave (
    input  req_valid, req_kind, sb_empty, mem_busy, ic_inv_ack,
    output req_ready, ic_inv_req, stall, done, redirect, illegal, timeout
  );
endinterface

// File: rtl/fence_unit.sv
// Executes FENCE / FENCE.I: drains stores and memory traffic, optionally invalidates
// the i-cache, then pulses done (and redirect for FENCE.I) while stalling the front end.
module fence_unit
  import fence_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  fence_if.slave     bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_INV   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int CW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DRAIN_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);
  localparam bit TMO_EN = (DRAIN_TIMEOUT > 0);

  state_t      state;
  state_t      state_next;
  fence_kind_t kind_q;
  logic [CW-1:0] cnt;
  logic        illegal_q;
  logic        timeout_q;

  logic        handshake;
  logic        req_is_fence;
  logic        drained;

  // Handshake: a request transfers on a rising edge where req_valid and req_ready are
  // both 1. req_ready is only offered in IDLE out of reset; nothing is queued elsewhere.
  assign handshake    = bus.req_valid && bus.req_ready;
  assign req_is_fence = (bus.req_kind == fk_fence) || (bus.req_kind == fk_fence_i);
  assign drained      = bus.sb_empty && !bus.mem_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (handshake && req_is_fence) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (drained) state_next = (kind_q == fk_fence_i) ? S_INV : S_DONE;
      end
      S_INV: begin
        if (bus.ic_inv_ack) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kind_q <= fk_fence;
    end else if (handshake && req_is_fence) begin
      kind_q <= bus.req_kind;
    end
  end

  // Counts unsuccessful drain cycles, saturating so the timeout pulse cannot repeat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (handshake && req_is_fence) begin
      cnt <= '0;
    end else if (state == S_DRAIN && !drained && cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      illegal_q <= handshake && !req_is_fence;
      timeout_q <= TMO_EN && (state == S_DRAIN) && !drained && (cnt == CNT_LAST);
    end
  end

  // Moore outputs; req_ready also gates on rst so it drops the moment reset asserts.
  assign bus.req_ready  = (state == S_IDLE) && rst;
  assign bus.stall      = (state != S_IDLE);
  assign bus.ic_inv_req = (state == S_INV);
  assign bus.done       = (state == S_DONE);
  assign bus.redirect   = (state == S_DONE) && (kind_q == fk_fence_i);
  assign bus.illegal    = illegal_q;
  assign bus.timeout    = timeout_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_fence_unit.sv
// Randomized bench for fence_unit: each transaction's expected timing is derived from
// drain/ack delays by arithmetic, queued in exp_q and compared with observed counts.
module tb_fence_unit;
  import fence_pkg::*;

  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] state_dbg;

  fence_if bus ();

  fence_unit #(.DRAIN_TIMEOUT(DT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.req_ready, bus.ic_inv_req, bus.stall, bus.done,
            bus.redirect, bus.illegal, bus.timeout};
  endfunction

  task automatic drive_idle();
    bus.req_valid  = 1'b0;
    bus.req_kind   = fk_fence;
    bus.sb_empty   = 1'b1;
    bus.mem_busy   = 1'b0;
    bus.ic_inv_ack = 1'b0;
  endtask

  // Reference: DRAIN lasts d+1 cycles, INV a+1 cycles (FENCE.I only), DONE one cycle.
  task automatic model_push(input fence_kind_t kind, input int d, input int a, input int last);
    bit is_fi, is_f;
    int e;
    is_fi = (kind == fk_fence_i);
    is_f  = (kind == fk_fence) || is_fi;
    e     = d + 2 + (is_fi ? a + 1 : 0);
    exp_q.push_back(is_f ? e : -1);                    // done_at
    exp_q.push_back(is_f ? 1 : 0);                     // done_cnt
    exp_q.push_back(is_fi ? 1 : 0);                    // redirect_cnt
    exp_q.push_back(is_f ? e : 0);                     // stall_cnt
    exp_q.push_back(is_fi ? a + 1 : 0);                // inv_cnt
    exp_q.push_back((is_f && d >= DT) ? 1 : 0);        // tmo_cnt
    exp_q.push_back((is_f && d >= DT) ? DT + 1 : -1);  // tmo_at
    exp_q.push_back(is_f ? 0 : 1);                     // illegal_cnt
    exp_q.push_back(is_f ? 2 : last + 1);              // ready_cnt
  endtask

  task automatic run_txn(input fence_kind_t kind, input int d, input int a, input bit hold);
    bit is_fi, is_f;
    int last, r;
    int done_at, done_cnt, redir_cnt, stall_cnt, inv_cnt, tmo_cnt, tmo_at, ill_cnt, rdy_cnt;
    is_fi = (kind == fk_fence_i);
    is_f  = (kind == fk_fence) || is_fi;
    last  = is_f ? d + 3 + (is_fi ? a + 1 : 0) : 3;
    model_push(kind, d, a, last);
    done_at = -1; tmo_at = -1;
    done_cnt = 0; redir_cnt = 0; stall_cnt = 0; inv_cnt = 0; tmo_cnt = 0; ill_cnt = 0; rdy_cnt = 0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (bus.done) begin done_at = c; done_cnt++; end
      if (bus.redirect) redir_cnt++;
      if (bus.stall) stall_cnt++;
      if (bus.ic_inv_req) inv_cnt++;
      if (bus.timeout) begin tmo_at = c; tmo_cnt++; end
      if (bus.illegal) ill_cnt++;
      if (bus.req_ready) rdy_cnt++;
      bus.req_valid = (c == 0) || (hold && is_f && c < last);
      bus.req_kind  = (c == 0) ? kind : fence_kind_t'($urandom_range(0, 3));
      if (c > d) begin
        bus.sb_empty = 1'b1;
        bus.mem_busy = 1'b0;
      end else begin
        r = $urandom_range(0, 2);
        bus.sb_empty = (r == 1);
        bus.mem_busy = (r != 0);
      end
      if (is_fi && c >= d + 2) bus.ic_inv_ack = (c >= d + 2 + a);
      else                     bus.ic_inv_ack = 1'($urandom_range(0, 1));
    end
    check_val("done_at",      done_at,   exp_q.pop_front());
    check_val("done_cnt",     done_cnt,  exp_q.pop_front());
    check_val("redirect_cnt", redir_cnt, exp_q.pop_front());
    check_val("stall_cnt",    stall_cnt, exp_q.pop_front());
    check_val("inv_cnt",      inv_cnt,   exp_q.pop_front());
    check_val("timeout_cnt",  tmo_cnt,   exp_q.pop_front());
    check_val("timeout_at",   tmo_at,    exp_q.pop_front());
    check_val("illegal_cnt",  ill_cnt,   exp_q.pop_front());
    check_val("ready_cnt",    rdy_cnt,   exp_q.pop_front());
  endtask

  task automatic reset_mid_inv();
    int inv_cnt, done_cnt, stall_cnt, rdy_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_kind = fk_fence_i;
    bus.sb_empty = 1'b1; bus.mem_busy = 1'b0; bus.ic_inv_ack = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_val("inv_before_rst", 32'(bus.ic_inv_req), 1);
    #2 rst = 1'b0;
    #1 check_val("outs_in_rst", 32'(outs()), 0);
    bus.ic_inv_ack = 1'b1;
    @(negedge clk);
    check_val("outs_rst_held", 32'(outs()), 0);
    rst = 1'b1;
    inv_cnt = 0; done_cnt = 0; stall_cnt = 0; rdy_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.ic_inv_req) inv_cnt++;
      if (bus.done) done_cnt++;
      if (bus.stall) stall_cnt++;
      if (bus.req_ready) rdy_cnt++;
    end
    check_val("post_rst_inv",   inv_cnt,   0);
    check_val("post_rst_done",  done_cnt,  0);
    check_val("post_rst_stall", stall_cnt, 0);
    check_val("post_rst_ready", rdy_cnt,   4);
    bus.ic_inv_ack = 1'b0;
  endtask

  initial begin
    fence_kind_t k;
    drive_idle();
    repeat (2) @(negedge clk);
    check_val("reset_outs", 32'(outs()), 0);
    rst = 1'b1;
    #1 check_val("ready_after_rst", 32'(bus.req_ready), 1);

    run_txn(fk_fence,   0, 0, 1'b0);
    run_txn(fk_fence_i, 0, 3, 1'b0);
    run_txn(fk_fence,   5, 0, 1'b0);
    run_txn(fk_invalid, 0, 0, 1'b0);
    run_txn(fence_kind_t'(2'd3), 0, 0, 1'b0);
    run_txn(fk_fence_i, 1, 0, 1'b1);
    run_txn(fk_fence_i, 4, 2, 1'b1);
    reset_mid_inv();
    run_txn(fk_fence,   0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      k = fence_kind_t'($urandom_range(0, 3));
      run_txn(k, $urandom_range(0, 6), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fence_unit.md
FENCE_UNIT -- requirements
Module: fence_unit

Interface
REQ-001 Parameter DRAIN_TIMEOUT, default 255, is the number of DRAIN cycles after which a timeout is flagged; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 req_valid  input  1  decoded fence instruction offered for execution.
REQ-005 req_kind  input  fence_kind_t  decoded kind: fk_fence, fk_fence_i or fk_invalid.
REQ-006 req_ready  output  1  unit can accept a request this cycle.
REQ-007 sb_empty  input  1  store buffer holds no pending stores.
REQ-008 mem_busy  input  1  memory loads or stores are outstanding.
REQ-009 ic_inv_req  output  1  instruction-cache invalidate request.
REQ-010 ic_inv_ack  input  1  instruction-cache invalidate complete.
REQ-011 stall  output  1  holds fetch and dispatch while a fence is in progress.
REQ-012 done  output  1  one-cycle pulse when a fence completes.
REQ-013 redirect  output  1  one-cycle pulse, coincident with done, requesting a refetch after FENCE.I.
REQ-014 illegal  output  1  one-cycle pulse when an fk_invalid request is accepted.
REQ-015 timeout  output  1  one-cycle pulse when the drain exceeds DRAIN_TIMEOUT.

Function
REQ-016 The FSM SHALL have the states IDLE, DRAIN, INV and DONE; all outputs except illegal and timeout SHALL be decoded from state only (Moore).
REQ-017 A handshake SHALL occur when req_valid=1 and req_ready=1 at a rising edge; req_ready SHALL be 1 only in IDLE with rst=1.
REQ-018 IDLE handshake with fk_fence or fk_fence_i: latch the kind, clear the drain counter, go to DRAIN.
REQ-019 IDLE handshake with fk_invalid: remain in IDLE; illegal=1 for exactly the next cycle; stall stays 0.
REQ-020 In DRAIN: stall=1; if sb_empty=1 and mem_busy=0 in a cycle, the next state SHALL be DONE for fence or INV for fence_i.
REQ-021 Drain counter: increments once per DRAIN cycle in which the drain condition is not met and saturates at DRAIN_TIMEOUT.
REQ-022 Timeout: pulse timeout=1 for one cycle when the counter first reaches DRAIN_TIMEOUT (DRAIN_TIMEOUT>0); the FSM keeps waiting in DRAIN with no further pulse.
REQ-023 In INV: stall=1; ic_inv_req=1 and held high until ic_inv_ack=1 is sampled, then go to DONE.
REQ-024 An ack that arrives in the first INV cycle SHALL be honoured; ic_inv_ack outside INV SHALL be ignored.
REQ-025 In DONE: stall=1, done=1, redirect=1 if the latched kind is fence_i (else 0); the next state SHALL be IDLE unconditionally.
REQ-026 Minimum latency, handshake cycle = T0, already drained: FENCE done at T2; FENCE.I ic_inv_req at T2, done at T3 if acked at T2.
REQ-027 req_valid and req_kind outside IDLE SHALL be ignored; no request is queued.
REQ-028 An unknown req_kind encoding SHALL be treated as fk_invalid.

Reset
REQ-029 While rst=0: state=IDLE, drain counter=0, latched kind=fk_fence.
REQ-030 While rst=0: req_ready, ic_inv_req, stall, done, redirect, illegal and timeout SHALL all be 0, taking effect asynchronously.
REQ-031 Reset asserted mid-operation (DRAIN or INV) SHALL abort the fence immediately: ic_inv_req drops without waiting for ack, and no done pulse is produced.
REQ-032 After rst rises, req_ready SHALL be 1 from the first rising edge.

Verification
REQ-033 FENCE, sb_empty=1, mem_busy=0, handshake at T0 -> stall=1 at T1..T2; done=1, redirect=0 at T2 only; req_ready=1 at T3.
REQ-034 FENCE.I, drained, ic_inv_ack held low 3 cycles then high -> ic_inv_req high from T2 to the ack cycle; done=1, redirect=1 one cycle after the ack.
REQ-035 FENCE with sb_empty=0 for 5 cycles (DRAIN_TIMEOUT=3) -> timeout pulses exactly once; done one cycle after sb_empty rises.
REQ-036 fk_invalid handshake -> illegal=1 for one cycle; stall=0 throughout; req_ready stays 1.
REQ-037 rst driven low while in INV with ic_inv_req=1 -> all outputs 0 immediately; after release, ic_inv_ack=1 is ignored and a new FENCE completes normally.
REQ-038 req_valid=1 held continuously during a FENCE.I -> exactly one fence is executed until the FSM returns to IDLE.
